// File: rtl/popcnt32_seq.sv
// Sequential population count / Hamming distance: counts one operand byte per cycle
// through a three-state IDLE/BUSY/DONE FSM with fixed latency of NBYTES+1 cycles.
module popcnt32_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_mode,
  input  logic [8*NBYTES-1:0]   i_a,
  input  logic [8*NBYTES-1:0]   i_b,
  output logic                  o_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [31:0]           o_result,
  output logic                  o_zero
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [1:0] IDX_LAST = 2'(NBYTES - 1);

  state_t                   r_state, w_next;
  logic [NBYTES-1:0][7:0]   r_operand;
  logic [5:0]               r_acc, r_result, w_sum;
  logic [1:0]               r_idx;
  logic [7:0]               w_byte;
  logic [3:0]               w_bytecnt;
  logic                     w_accept, w_last;

  assign w_accept = (r_state == IDLE) && i_start;
  assign w_last   = (r_idx == IDX_LAST);
  assign w_byte   = r_operand[r_idx];

  always_comb begin
    w_bytecnt = '0;
    for (int i = 0; i < 8; i++) w_bytecnt = w_bytecnt + {3'b000, w_byte[i]};
  end

  // Max sum is 32, so 6 bits never overflow.
  assign w_sum = r_acc + {2'b00, w_bytecnt};

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    o_ready = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    case (r_state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_start) w_next = BUSY;
      end
      BUSY: begin
        o_busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        o_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_operand <= '0;
      r_acc     <= '0;
      r_idx     <= '0;
      r_result  <= '0;
    end else if (w_accept) begin
      r_operand <= i_mode ? (i_a ^ i_b) : i_a;
      r_acc     <= '0;
      r_idx     <= '0;
    end else if (r_state == BUSY) begin
      r_acc <= w_sum;
      r_idx <= r_idx + 2'd1;
      if (w_last) r_result <= w_sum;
    end
  end

  assign o_result = {26'd0, r_result};
  assign o_zero   = (r_result == 6'd0);

endmodule

// File: tb/tb_popcnt32_seq.sv
// Self-checking bench for popcnt32_seq: directed corner cases plus random operations
// on a 4-byte and a 1-byte instance, compared against a $countones reference.
module tb_popcnt32_seq;

  logic        clk, rst, mode, start0, start1;
  logic [31:0] a, b;
  logic        ready0, busy0, done0, zero0;
  logic        ready1, busy1, done1, zero1;
  logic [31:0] result0, result1;
  bit          sel;
  logic        s_ready, s_busy, s_done, s_zero;
  logic [31:0] s_result;
  int          n_checks = 0, n_pass = 0, n_fail = 0;

  popcnt32_seq #(.NBYTES(4)) u0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .i_mode(mode), .i_a(a), .i_b(b),
    .o_ready(ready0), .o_busy(busy0), .o_done(done0), .o_result(result0), .o_zero(zero0));

  popcnt32_seq #(.NBYTES(1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_mode(mode), .i_a(a[7:0]), .i_b(b[7:0]),
    .o_ready(ready1), .o_busy(busy1), .o_done(done1), .o_result(result1), .o_zero(zero1));

  assign s_ready  = sel ? ready1  : ready0;
  assign s_busy   = sel ? busy1   : busy0;
  assign s_done   = sel ? done1   : done0;
  assign s_zero   = sel ? zero1   : zero0;
  assign s_result = sel ? result1 : result0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation on the selected instance; expected value is the bit count of the
  // operand bytes the instance sees, and latency is NBYTES+1 samples after acceptance.
  task automatic do_op(input bit s, input logic m, input logic [31:0] av, input logic [31:0] bv,
                       input bit scramble);
    int nb, lat;
    logic [31:0] x, exp, prev;
    nb = s ? 1 : 4;
    x  = m ? (av ^ bv) : av;
    if (s) x = x & 32'h0000_00FF;
    exp = $countones(x);
    @(negedge clk);
    sel = s;
    #1;
    check("ready_idle", s_ready, 1);
    prev = s_result;
    mode = m; a = av; b = bv;
    if (s) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    if (scramble) begin a = $urandom; b = $urandom; mode = 1'($urandom_range(0, 1)); end
    lat = 1;
    while (!s_done && lat < 20) begin
      check("busy", s_busy, 1);
      check("result_hold", s_result, prev);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, nb + 1);
    check("result", s_result, exp);
    check("zero", s_zero, exp == 0);
    @(negedge clk);
    check("done_single", s_done, 0);
    check("ready_after", s_ready, 1);
  endtask

  initial begin
    int dones, first, second, lat;
    clk = 0; rst = 1; start0 = 0; start1 = 0; mode = 0; a = 0; b = 0; sel = 0;
    repeat (2) @(negedge clk);
    check("rst_ready", ready0, 1);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_result", result0, 0);
    check("rst_zero", zero0, 1);
    check("rst_ready1", ready1, 1);
    rst = 0;

    do_op(0, 0, 32'hFFFF_FFFF, 32'h0, 0);
    check("allones", result0, 32'h20);
    do_op(0, 1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 0);
    check("hamming32", result0, 32);
    do_op(0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    check("hamming0", result0, 0);
    check("hamming0_zero", zero0, 1);
    do_op(0, 0, 32'h1234_5678, 32'h0, 1);
    check("stable13", result0, 13);
    do_op(1, 0, 32'h0000_00A5, 32'h0, 0);
    check("nb1_a5", result1, 4);

    for (int i = 0; i < 16; i++) do_op(0, 1'($urandom_range(0, 1)), $urandom, $urandom, 1);
    for (int i = 0; i < 6; i++)  do_op(1, 1'($urandom_range(0, 1)), $urandom, $urandom, 1);

    // start held high for 10 edges: accepts at edges 1 and 7
    sel = 0;
    @(negedge clk);
    a = 32'h1; mode = 0; start0 = 1; dones = 0; first = 0; second = 0;
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      if (j == 10) start0 = 0;
      if (j == 6) check("held_ready", ready0, 1);
      if (done0) begin
        dones++;
        check("held_result", result0, 1);
        if (first == 0) first = j; else second = j;
      end
    end
    check("held_dones", dones, 2);
    check("held_first", first, 5);
    check("held_second", second, 11);

    // reset in the 2nd BUSY cycle aborts with no done
    @(negedge clk);
    a = 32'hFFFF; start0 = 1;
    @(negedge clk);
    start0 = 0;
    check("abort_busy1", busy0, 1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("abort_ready", ready0, 1);
    check("abort_busy", busy0, 0);
    check("abort_result", result0, 0);
    check("abort_zero", zero0, 1);
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done0) dones++;
    end
    check("abort_nodone", dones, 0);

    // reset beats start; first start accepted right after release
    rst = 1; start0 = 1; a = 32'h0000_00FF; mode = 0;
    @(negedge clk);
    check("prio_ready", ready0, 1);
    check("prio_busy", busy0, 0);
    rst = 0;
    @(negedge clk);
    start0 = 0;
    check("first_accept", busy0, 1);
    lat = 1;
    while (!done0 && lat < 20) begin @(negedge clk); lat++; end
    check("first_latency", lat, 5);
    check("first_result", result0, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
